// File: rtl/keypad_pkg.sv
// Shared key codes, matrix lookup and debounce FSM states for the 4x4 keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row driver: synchronizes columns, dwells on each row, and reports the
// first pressed key (lowest row, then lowest column) once per 4-row frame.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       frame_done,
  output logic       frame_hit,
  output logic [3:0] frame_code
);

  localparam int unsigned DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    row_idx;
  logic          acc_hit;
  logic [3:0]    acc_code;
  logic          row_hit;
  logic [3:0]    row_code;
  logic          dwell_end;

  assign dwell_end = (dwell == DWELL_LAST);

  always_comb begin
    row_hit  = 1'b0;
    row_code = KEY_0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!col_sync[c] && !row_hit) begin
        row_hit  = 1'b1;
        row_code = key_lookup(row_idx, 2'(c));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta   <= '1;
      col_sync   <= '1;
      dwell      <= '0;
      row_idx    <= '0;
      row_n      <= 4'b1110;
      acc_hit    <= 1'b0;
      acc_code   <= '0;
      frame_done <= 1'b0;
      frame_hit  <= 1'b0;
      frame_code <= '0;
    end else begin
      col_meta   <= col_n;
      col_sync   <= col_meta;
      frame_done <= 1'b0;
      if (dwell_end) begin
        dwell   <= '0;
        row_n   <= {row_n[2:0], row_n[3]};
        row_idx <= row_idx + 2'd1;
        if (row_idx == 2'd3) begin
          // Row 3 result merges in directly so the frame closes on this edge.
          frame_done <= 1'b1;
          frame_hit  <= acc_hit | row_hit;
          frame_code <= acc_hit ? acc_code : row_code;
          acc_hit    <= 1'b0;
          acc_code   <= '0;
        end else if (!acc_hit && row_hit) begin
          acc_hit  <= 1'b1;
          acc_code <= row_code;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan plus frame-level debounce FSM that issues one
// key_valid strobe per accepted press and suppresses rollover until release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES    = 500000,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);

  logic          frame_done;
  logic          frame_hit;
  logic [3:0]    frame_code;

  state_t        state, state_next;
  logic [3:0]    cand, cand_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]    code_next;
  logic          valid_next;
  logic          held_next;
  logic          same_key;

  keypad_row_scan #(
    .SCAN_CYCLES(SCAN_CYCLES)
  ) u_row_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .frame_done(frame_done),
    .frame_hit (frame_hit),
    .frame_code(frame_code)
  );

  assign cnt_inc  = cnt + CW'(1);
  assign same_key = frame_hit && (frame_code == cand);

  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    code_next  = key_code;
    valid_next = 1'b0;
    held_next  = key_held;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_hit) begin
            state_next = DEBOUNCE;
            cand_next  = frame_code;
            cnt_next   = CW'(1);
          end
        end
        DEBOUNCE: begin
          if (!frame_hit) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (same_key) begin
            if (cnt_inc == CNT_TARGET) begin
              state_next = PRESSED;
              cnt_next   = '0;
              code_next  = cand;
              valid_next = 1'b1;
              held_next  = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cand_next = frame_code;
            cnt_next  = CW'(1);
          end
        end
        PRESSED: begin
          if (!same_key) begin
            state_next = RELEASE;
            cnt_next   = CW'(1);
          end
        end
        RELEASE: begin
          // Bounce back to the held key resumes PRESSED without a new strobe.
          if (same_key) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else if (cnt_inc == CNT_TARGET) begin
            state_next = IDLE;
            cnt_next   = '0;
            held_next  = 1'b0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      cand      <= cand_next;
      cnt       <= cnt_next;
      key_code  <= code_next;
      key_valid <= valid_next;
      key_held  <= held_next;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with an 8-cycle dwell (32-cycle frame) and
// a combinational membrane-matrix model driving col_n from row_n.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int n_checks;
  int n_fail;
  int cyc;
  int valid_count;
  int last_valid_cyc;
  int last_code;
  int held_seen;

  keypad_scanner #(
    .SCAN_CYCLES   (8),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_count    = 0;
      last_valid_cyc = -1;
      last_code      = -1;
      held_seen      = 0;
    end else begin
      if (key_valid) begin
        valid_count++;
        last_valid_cyc = cyc;
        last_code      = int'(key_code);
      end
      if (key_held) held_seen = 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] kb(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  task automatic reset_dut(input logic [15:0] k);
    keys  = k;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic single_press(input string tag, input logic [15:0] k, input int exp);
    reset_dut(k);
    run_to(98);
    check({tag, "_count"}, valid_count, 1);
    check({tag, "_cycle"}, last_valid_cyc, 97);
    check({tag, "_code"}, last_code, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    keys     = '0;
    rst_n    = 1'b0;

    // 1: reset state and idle row rotation
    @(negedge clk);
    #1;
    check("rst_row_n", int'(row_n), 4'b1110);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    reset_dut('0);
    run_to(7);  check("idle_row_c7", int'(row_n), 4'b1110);
    run_to(8);  check("idle_row_c8", int'(row_n), 4'b1101);
    run_to(16); check("idle_row_c16", int'(row_n), 4'b1011);
    run_to(24); check("idle_row_c24", int'(row_n), 4'b0111);
    run_to(32); check("idle_row_c32", int'(row_n), 4'b1110);
    run_to(64);
    check("idle_valid_count", valid_count, 0);
    check("idle_key_code", int'(key_code), 0);
    check("idle_held_seen", held_seen, 0);

    // 2: hold key 6 for 10 frames, then release
    reset_dut(kb(1, 2));
    run_to(96); check("k6_valid_c96", int'(key_valid), 0);
    run_to(97); check("k6_valid_c97", int'(key_valid), 1);
                check("k6_code_c97", int'(key_code), 6);
    run_to(98); check("k6_valid_c98", int'(key_valid), 0);
    run_to(320);
    keys = '0;
    run_to(416); check("k6_held_c416", int'(key_held), 1);
    run_to(417); check("k6_held_c417", int'(key_held), 0);
    check("k6_valid_count", valid_count, 1);
    check("k6_code_hold", int'(key_code), 6);

    // 3: key 5 toggling every frame never debounces
    reset_dut(kb(1, 1));
    for (int f = 0; f < 12; f++) begin
      keys = (f % 2 == 0) ? kb(1, 1) : 16'h0000;
      run_to(32 * (f + 1));
    end
    check("toggle_valid_count", valid_count, 0);
    check("toggle_held_seen", held_seen, 0);

    // 4: priority and special codes
    single_press("pri_1_9", kb(0, 0) | kb(2, 2), 4'h1);
    single_press("pri_5_b", kb(1, 1) | kb(1, 3), 4'h5);
    single_press("star", kb(3, 0), 4'hE);
    single_press("hash", kb(3, 2), 4'hF);
    single_press("key_d", kb(3, 3), 4'hD);
    single_press("key_0", kb(3, 1), 4'h0);

    // 5: release bounce on 4, then rollover from 4 to 7
    reset_dut(kb(1, 0));
    run_to(160);
    keys = '0;
    run_to(192);
    keys = kb(1, 0);
    run_to(224); check("bounce_held_c224", int'(key_held), 1);
    run_to(256);
    check("bounce_valid_count", valid_count, 1);
    check("bounce_code", last_code, 4);
    keys = kb(2, 0);
    run_to(288); check("roll_held_c288", int'(key_held), 1);
    run_to(352); check("roll_held_c352", int'(key_held), 1);
    run_to(353); check("roll_held_c353", int'(key_held), 0);
    run_to(450);
    check("roll_valid_count", valid_count, 2);
    check("roll_valid_cycle", last_valid_cyc, 449);
    check("roll_code", int'(key_code), 7);

    // 6: asynchronous reset while key 8 is held
    reset_dut(kb(2, 1));
    run_to(150);
    check("pre_rst_held", int'(key_held), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_row_n", int'(row_n), 4'b1110);
    check("mid_rst_code", int'(key_code), 0);
    check("mid_rst_held", int'(key_held), 0);
    check("mid_rst_valid", int'(key_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_to(98);
    check("post_rst_count", valid_count, 1);
    check("post_rst_cycle", last_valid_cyc, 97);
    check("post_rst_code", last_code, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
